// File: rtl/scan_crypt_sequencer_if.sv
// scan_crypt_sequencer_if: key load, vector and response handshakes for scan_crypt_sequencer.
//   key_load/key_in       : key register load strobe and value
//   vec_valid/vec_ready   : plaintext vector handshake, vec_data carries the vector
//   resp_valid/resp_ready : decrypted response handshake, resp_data carries the response
//   master = producer/consumer side, slave = sequencer side
interface scan_crypt_sequencer_if #(
    parameter int CHAIN_LEN = 128
);
    logic                 key_load;
    logic [CHAIN_LEN-1:0] key_in;
    logic                 vec_valid;
    logic                 vec_ready;
    logic [CHAIN_LEN-1:0] vec_data;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [CHAIN_LEN-1:0] resp_data;

    modport master (
        output key_load, key_in, vec_valid, vec_data, resp_ready,
        input  vec_ready, resp_valid, resp_data
    );

    modport slave (
        input  key_load, key_in, vec_valid, vec_data, resp_ready,
        output vec_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/scan_crypt_sequencer.sv
// scan_crypt_sequencer: XOR-encrypts a vector, shifts it through a scan chain, captures, unloads and decrypts the response.
//   clk, reset_n (async, active-low)
//   bus       : scan_crypt_sequencer_if.slave (key load, vector and response handshakes)
//   scan_en   : 1 = shift path, 0 = functional capture
//   scan_in   : serial data into cell 0; scan_out : serial data from cell CHAIN_LEN-1
//   busy      : controller not idle
//   sig_clear : zero the MISR while idle; signature : MISR value
//   Optional MISR over the raw unloaded bits is enabled by defining SCAN_MISR_EN.
module scan_crypt_sequencer #(
    parameter int CHAIN_LEN      = 128,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    scan_crypt_sequencer_if.slave  bus,
    output logic                   scan_en,
    output logic                   scan_in,
    input  logic                   scan_out,
    output logic                   busy,
    input  logic                   sig_clear,
    output logic [31:0]            signature
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] LAST_CAP   = CW'(CAPTURE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, RESP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [CHAIN_LEN-1:0] key, key_n, sr, sr_n, resp_q, resp_n;
    logic                 en_q, en_n, in_q, in_n, rv_q, rv_n, idle_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            key    <= '0;
            sr     <= '0;
            resp_q <= '0;
            en_q   <= 1'b0;
            in_q   <= 1'b0;
            rv_q   <= 1'b0;
            idle_q <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            key    <= key_n;
            sr     <= sr_n;
            resp_q <= resp_n;
            en_q   <= en_n;
            in_q   <= in_n;
            rv_q   <= rv_n;
            idle_q <= state_n == IDLE;
        end
    end

    // Outputs are computed one cycle ahead so every pin comes straight from a flop.
    // sr holds the ciphertext while loading (MSB leaves first) and then collects
    // the raw response while unloading.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        key_n   = key;
        sr_n    = sr;
        resp_n  = resp_q;
        en_n    = 1'b0;
        in_n    = 1'b0;
        rv_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.key_load)
                    key_n = bus.key_in;
                if (bus.vec_valid) begin
                    state_n = LOAD;
                    sr_n    = bus.vec_data ^ key;
                    en_n    = 1'b1;
                    in_n    = sr_n[CHAIN_LEN-1];
                end
            end
            LOAD: begin
                sr_n = sr << 1;
                en_n = cnt != LAST_SHIFT;
                in_n = cnt != LAST_SHIFT && sr[CHAIN_LEN-2];
                if (cnt == LAST_SHIFT) begin
                    state_n = CAPTURE;
                    cnt_n   = '0;
                end
            end
            CAPTURE: begin
                en_n = cnt == LAST_CAP;
                if (cnt == LAST_CAP) begin
                    state_n = UNLOAD;
                    cnt_n   = '0;
                end
            end
            UNLOAD: begin
                sr_n = {sr[CHAIN_LEN-2:0], scan_out};
                en_n = cnt != LAST_SHIFT;
                if (cnt == LAST_SHIFT) begin
                    state_n = RESP;
                    cnt_n   = '0;
                    resp_n  = sr_n ^ key;
                    rv_n    = 1'b1;
                end
            end
            RESP: begin
                cnt_n = '0;
                rv_n  = !bus.resp_ready;
                if (bus.resp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.vec_ready  = idle_q;
    assign bus.resp_valid = rv_q;
    assign bus.resp_data  = resp_q;
    assign busy           = ~idle_q;
    assign scan_en        = en_q;
    assign scan_in        = in_q;

`ifdef SCAN_MISR_EN
    logic [31:0] sig;

    // Signature covers the raw ciphertext coming off the chain, never the decrypted data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sig <= '0;
        else if (state == IDLE && sig_clear)
            sig <= '0;
        else if (state == UNLOAD)
            sig <= {sig[30:0], 1'b0} ^ (sig[31] ? 32'h0040_0007 : 32'h0) ^ {31'b0, scan_out};
    end

    assign signature = sig;
`else
    logic unused_sig_clear;

    assign unused_sig_clear = sig_clear;
    assign signature        = '0;
`endif
endmodule

// File: tb/tb_scan_crypt_sequencer.sv
// tb_scan_crypt_sequencer: directed bench for scan_crypt_sequencer against a 128-cell scan chain model.
//   Chain model captures the inverted cell contents, or a fixed pattern when cap_fixed is set.
module tb_scan_crypt_sequencer;
    localparam int N = 128;
    localparam logic [N-1:0] A5  = {16{8'hA5}};
    localparam logic [N-1:0] X5A = {16{8'h5A}};
    localparam logic [N-1:0] K1  = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [N-1:0] K2  = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    localparam logic [N-1:0] V4  = 128'hDEADBEEF_CAFEF00D_12345678_9ABC0FF0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scan_en, scan_in, scan_out, busy, sig_clear;
    logic [31:0] signature;
    logic [N-1:0] chain = '0;
    logic cap_fixed = 1'b0;
    logic [N-1:0] cap_val = '0;
    logic [N-1:0] stream;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scan_crypt_sequencer_if #(.CHAIN_LEN(N)) bus ();

    scan_crypt_sequencer #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .scan_en(scan_en),
        .scan_in(scan_in),
        .scan_out(scan_out),
        .busy(busy),
        .sig_clear(sig_clear),
        .signature(signature)
    );

    always @(posedge clk)
        chain <= scan_en ? {chain[N-2:0], scan_in} : (cap_fixed ? cap_val : ~chain);

    assign scan_out = chain[N-1];

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_key(input logic [N-1:0] k);
        @(negedge clk);
        bus.key_load = 1'b1;
        bus.key_in   = k;
        @(negedge clk);
        bus.key_load = 1'b0;
    endtask

    // Offers v, records scan_in during LOAD, checks latency/response, holds resp_ready low for hold cycles.
    task automatic run_vec(input logic [N-1:0] v, input int hold, input bit kl, input logic [N-1:0] kl_key,
                           input logic [N-1:0] exp, output logic [N-1:0] s);
        int k;
        int lat;
        @(negedge clk);
        check("vec_ready_idle", bus.vec_ready, 1);
        bus.vec_valid = 1'b1;
        bus.vec_data  = v;
        @(posedge clk);
        @(negedge clk);
        bus.vec_valid = 1'b0;
        s   = '0;
        lat = -1;
        k   = 1;
        while (k <= 1000) begin
            if (k <= N)
                s = {s[N-2:0], scan_in};
            if (kl) begin
                bus.key_load = (k == 20);
                bus.key_in   = kl_key;
            end
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
            k++;
        end
        bus.key_load = 1'b0;
        check("resp_latency", N'(lat), N'(258));
        check("resp_data", bus.resp_data, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_resp_data", bus.resp_data, exp);
            check("hold_resp_valid", bus.resp_valid, 1);
            check("hold_vec_ready", bus.vec_ready, 0);
            check("hold_busy", busy, 1);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("vec_ready_after_resp", bus.vec_ready, 1);
        check("resp_valid_after_resp", bus.resp_valid, 0);
        check("busy_after_resp", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.key_load   = 1'b0;
        bus.key_in     = '0;
        bus.vec_valid  = 1'b0;
        bus.vec_data   = '0;
        bus.resp_ready = 1'b0;
        sig_clear      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vec_ready", bus.vec_ready, 1);
        check("rst_scan_en", scan_en, 0);
        check("rst_scan_in", scan_in, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_signature", N'(signature), 0);
        reset_n = 1'b1;

        run_vec(A5, 0, 1'b0, '0, X5A, stream);
        check("stream_key0", stream, A5);

        load_key(K1);
        run_vec('0, 10, 1'b0, '0, '1, stream);
        check("stream_key1", stream, K1);

        run_vec(V4, 0, 1'b1, K2, ~V4, stream);
        check("stream_v4", stream, V4 ^ K1);
        run_vec('0, 0, 1'b0, '0, '1, stream);
        check("stream_key_unchanged", stream, K1);

        @(negedge clk);
        bus.vec_valid = 1'b1;
        bus.vec_data  = A5;
        @(posedge clk);
        @(negedge clk);
        bus.vec_valid = 1'b0;
        repeat (39) @(negedge clk);
        check("mid_load_scan_en", scan_en, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_scan_en", scan_en, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_vec_ready", bus.vec_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(A5, 0, 1'b0, '0, X5A, stream);
        check("stream_after_rst", stream, A5);

`ifdef SCAN_MISR_EN
        @(negedge clk);
        sig_clear = 1'b1;
        @(negedge clk);
        sig_clear = 1'b0;
        check("sig_cleared", N'(signature), 0);
        cap_fixed = 1'b1;
        cap_val   = '0;
        run_vec(A5, 0, 1'b0, '0, '0, stream);
        check("sig_zeros", N'(signature), 0);
        @(negedge clk);
        sig_clear = 1'b1;
        @(negedge clk);
        sig_clear = 1'b0;
        cap_val   = N'(1);
        run_vec(A5, 0, 1'b0, '0, N'(1), stream);
        check("sig_one", N'(signature), N'(1));
        cap_fixed = 1'b0;
`else
        check("sig_disabled", N'(signature), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
